// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding, default
// parameter values, bytes-per-word constant and the word address helper.
// Optional feature macro: BOOT_SEQUENCER_CHECKSUM_EN adds the CHK state.
package boot_pkg;

  localparam int unsigned  DEF_MEM_WORDS   = 1024;
  localparam logic [31:0]  DEF_BASE_ADDR   = 32'h0000_0000;
  localparam int unsigned  DEF_HOLD_CYCLES = 4;
  localparam int unsigned  BYTES_PER_WORD  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
`ifdef BOOT_SEQUENCER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Byte address of loaded word number idx.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words (first byte -> [7:0]).
// Latency: complete/word are combinational on the accept of the last byte.
// Backpressure: none; the caller only strobes accept on real transfers.
// Ports: clk/reset (async active-low), accept_i strobe, data_i byte,
//        clear_i drops any partial word, word_o packed word, complete_o flag.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      merged;

  // The word including the byte currently on data_i, so the caller can
  // capture a complete word in the same cycle the last byte is accepted.
  always_comb begin
    merged = word_q;
    merged[{cnt_q, 3'b000} +: 8] = data_i;
  end

  assign complete_o = accept_i && (cnt_q == LAST_SLOT);
  assign word_o     = merged;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept_i) begin
      word_d = complete_o ? '0 : merged;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Loads a length-prefixed byte stream into unified memory, then releases the
// core from reset and hands the memory port over to it.
// Latency: 4th byte of a word accepted in cycle t -> mem_we in t+1.
// Backpressure: rx_ready is registered and high only in LEN0/LEN1/DATA/CHK.
// Ports: clk, reset (async active-low), rx_valid/rx_data/rx_ready byte
//        stream, reload pulse, core_* memory request from the core, mem_* to
//        memory, core_reset, done, error.
// Macro BOOT_SEQUENCER_CHECKSUM_EN: adds an XOR checksum trailing byte (CHK).
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [31:0] core_adr,
  input  logic        core_we,
  input  logic [31:0] core_wdata,
  output logic [31:0] mem_adr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  // Where the load goes once the data words (or an empty program) are done.
`ifdef BOOT_SEQUENCER_CHECKSUM_EN
  localparam state_t TAIL_ST = ST_CHK;
`else
  localparam state_t TAIL_ST = ST_RELEASE;
`endif

  state_t      state_q, state_d;
  logic [7:0]  n_lo_q, n_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        rx_ready_q, rx_ready_d;
  logic        core_reset_q, core_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        rx_fire;
  logic        pk_accept;
  logic        pk_clear;
  logic        pk_done;
  logic [31:0] pk_word;
  logic [15:0] len_w;
  logic [15:0] idx_inc;

  assign rx_fire   = rx_valid && rx_ready_q;
  assign pk_accept = (state_q == ST_DATA) && rx_fire;
  // Reload only restarts a finished or failed load; elsewhere it is ignored.
  assign pk_clear  = (state_q == ST_IDLE) ||
                     (((state_q == ST_RUN) || (state_q == ST_ERROR)) && reload);
  assign len_w     = {rx_data, n_lo_q};
  assign idx_inc   = idx_q + 16'd1;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (pk_accept),
    .data_i     (rx_data),
    .clear_i    (pk_clear),
    .word_o     (pk_word),
    .complete_o (pk_done)
  );

`ifdef BOOT_SEQUENCER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR over length and data bytes; the trailing byte must match it.
  always_comb begin
    csum_d = csum_q;
    if (rx_fire && ((state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                    (state_q == ST_DATA))) begin
      csum_d = csum_q ^ rx_data;
    end
    if (pk_clear) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    n_lo_d      = n_lo_q;
    n_d         = n_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_fire) begin
          n_lo_d  = rx_data;
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_fire) begin
          n_d = len_w;
          if ({16'h0, len_w} > MEM_WORDS) begin
            state_d = ST_ERROR;
          end else if (len_w == 16'd0) begin
            state_d = TAIL_ST;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_done) begin
          state_d     = ST_WRITE;
          mem_adr_d   = word_addr(BASE_ADDR, idx_q);
          mem_wdata_d = pk_word;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc < n_q) ? ST_DATA : TAIL_ST;
      end
`ifdef BOOT_SEQUENCER_CHECKSUM_EN
      ST_CHK: begin
        if (rx_fire) begin
          state_d = (rx_data == csum_q) ? ST_RELEASE : ST_ERROR;
        end
      end
`endif
      ST_RELEASE: begin
        // hold_q is always zero on entry: it is cleared when leaving.
        if ({16'h0, hold_q} + 32'd1 >= HOLD_CYCLES) begin
          hold_d  = '0;
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          state_d = ST_LEN0;
          n_lo_d  = '0;
          n_d     = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    rx_ready_d   = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
`ifdef BOOT_SEQUENCER_CHECKSUM_EN
                   (state_d == ST_CHK) ||
`endif
                   (state_d == ST_DATA);
    mem_we_d     = (state_d == ST_WRITE);
    core_reset_d = (state_d != ST_RUN);
    done_d       = (state_d == ST_RUN);
    error_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      n_lo_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      mem_adr_q    <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rx_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_lo_q       <= n_lo_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      mem_adr_q    <= mem_adr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rx_ready_q   <= rx_ready_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // The core owns the memory port only while running.
  assign mem_adr    = (state_q == ST_RUN) ? core_adr   : mem_adr_q;
  assign mem_we     = (state_q == ST_RUN) ? core_we    : mem_we_q;
  assign mem_wdata  = (state_q == ST_RUN) ? core_wdata : mem_wdata_q;
  assign rx_ready   = rx_ready_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
